// File: rtl/rpll_lock_sequencer.sv
// rPLL reset/lock sequencer with handshaked PSDA/DUTYDA/FDLY control; outputs registered, lock input 2-FF synchronised.
// cfg_ready is high only in RUN, so requests stall through lock-up and ADJUST; define RPLL_AUTO_RELOCK_EN to re-sequence on lock loss instead of faulting.
module rpll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [3:0]  DUTY_RESET    = 4'b1000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  input  logic [3:0] cfg_fdly,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  output logic [3:0] pll_fdly,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_ADJUST, S_FAULT
  } state_t;

`ifdef RPLL_AUTO_RELOCK_EN
  localparam state_t LOSS_STATE = S_PLL_RST;
`else
  localparam state_t LOSS_STATE = S_FAULT;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    retry_q, retry_d, retry_inc;
  logic [3:0]    psda_q, psda_d, duty_q, duty_d, fdly_q, fdly_d;
  logic          sync1_q, lock_s_q;
  logic          pll_reset_q, sys_rst_q, ready_q, fault_q, cfg_ready_q;

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    psda_d  = psda_q;
    duty_d  = duty_q;
    fdly_d  = fdly_q;
    if (restart) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q >= RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        end
        S_WAIT_LOCK: begin
          // The sampling cycle that sees lock counts as the first stable high.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = CW'(1);
          end else if (cnt_q >= TMO_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_MAX) ? S_FAULT : S_PLL_RST;
          end else cnt_d = cnt_inc;
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else cnt_d = cnt_inc;
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = LOSS_STATE;
            cnt_d   = '0;
          end else if (cfg_valid && cfg_ready_q) begin
            psda_d  = cfg_psda;
            duty_d  = cfg_dutyda;
            fdly_d  = cfg_fdly;
            state_d = S_ADJUST;
            cnt_d   = '0;
          end
        end
        S_ADJUST: begin
          if (!lock_s_q) begin
            state_d = LOSS_STATE;
            cnt_d   = '0;
          end else if (cnt_q >= SET_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        end
        S_FAULT: ;
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      psda_q      <= '0;
      duty_q      <= DUTY_RESET;
      fdly_q      <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      psda_q      <= psda_d;
      duty_q      <= duty_d;
      fdly_q      <= fdly_d;
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      pll_reset_q <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      sys_rst_q   <= !((state_d == S_RUN) || (state_d == S_ADJUST));
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
      cfg_ready_q <= (state_d == S_RUN);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_reset_p = 1'b0;
  assign pll_psda    = psda_q;
  assign pll_dutyda  = duty_q;
  assign pll_fdly    = fdly_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign cfg_ready   = cfg_ready_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_rpll_lock_sequencer.sv
// Randomised bench for rpll_lock_sequencer: a phase-level reference model predicts each cycle's outputs into a queue, a monitor compares.
module tb_rpll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TMO_C = 20;
  localparam int STB_C = 8;
  localparam int SET_C = 5;
  localparam int RTY_C = 3;

  typedef struct packed {
    logic       pll_reset;
    logic       pll_reset_p;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic [3:0] fdly;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic       cfg_ready;
    logic [3:0] retry;
  } out_t;

  logic       clkin = 1'b0;
  logic       reset, pll_lock, restart, cfg_valid;
  logic [3:0] cfg_psda, cfg_dutyda, cfg_fdly;
  logic       cfg_ready, pll_reset, pll_reset_p, sys_rst, ready, fault;
  logic [3:0] pll_psda, pll_dutyda, pll_fdly, retry_cnt;

  int total = 0;
  int bad   = 0;
  out_t exp_q[$];

  rpll_lock_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TMO_C), .STABLE_CYCLES(STB_C),
    .SETTLE_CYCLES(SET_C), .MAX_RETRY(RTY_C), .DUTY_RESET(4'b1000)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .restart(restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_psda(cfg_psda),
    .cfg_dutyda(cfg_dutyda), .cfg_fdly(cfg_fdly), .pll_reset(pll_reset),
    .pll_reset_p(pll_reset_p), .pll_psda(pll_psda), .pll_dutyda(pll_dutyda),
    .pll_fdly(pll_fdly), .sys_rst(sys_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  // Reference model: which phase the sequencer is in, how long it has been there,
  // and the lock input as seen through a two-sample delay line.
  localparam int PH_RESET = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_ADJ = 4, PH_FAULT = 5;
  int         m_phase, m_elapsed, m_highs, m_retry;
  logic [3:0] m_psda, m_duty, m_fdly;
  logic       m_s1, m_s2;

  function automatic out_t dut_out();
    out_t o;
    o.pll_reset = pll_reset;  o.pll_reset_p = pll_reset_p;
    o.psda = pll_psda;        o.dutyda = pll_dutyda;  o.fdly = pll_fdly;
    o.sys_rst = sys_rst;      o.ready = ready;        o.fault = fault;
    o.cfg_ready = cfg_ready;  o.retry = retry_cnt;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.pll_reset   = (m_phase == PH_RESET) || (m_phase == PH_FAULT);
    o.pll_reset_p = 1'b0;
    o.psda        = m_psda;
    o.dutyda      = m_duty;
    o.fdly        = m_fdly;
    o.sys_rst     = !((m_phase == PH_RUN) || (m_phase == PH_ADJ));
    o.ready       = (m_phase == PH_RUN);
    o.fault       = (m_phase == PH_FAULT);
    o.cfg_ready   = (m_phase == PH_RUN);
    o.retry       = 4'(m_retry);
    return o;
  endfunction

  task automatic enter(input int ph);
    m_phase   = ph;
    m_elapsed = 0;
  endtask

  task automatic model_reset();
    m_phase = PH_RESET; m_elapsed = 0; m_highs = 0; m_retry = 0;
    m_psda = 4'h0; m_duty = 4'b1000; m_fdly = 4'h0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic lock_lost();
`ifdef RPLL_AUTO_RELOCK_EN
    enter(PH_RESET);
`else
    enter(PH_FAULT);
`endif
  endtask

  task automatic model_step();
    logic seen;
    if (reset) begin
      model_reset();
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_lock;
    if (restart) begin
      m_retry = 0;
      enter(PH_RESET);
      return;
    end
    case (m_phase)
      PH_RESET: begin
        m_elapsed++;
        if (m_elapsed == RST_C) enter(PH_WAIT);
      end
      PH_WAIT: begin
        if (seen) begin
          m_highs = 1;
          enter(PH_STAB);
        end else begin
          m_elapsed++;
          if (m_elapsed == TMO_C) begin
            m_retry++;
            enter((m_retry == RTY_C) ? PH_FAULT : PH_RESET);
          end
        end
      end
      PH_STAB: begin
        if (!seen) enter(PH_WAIT);
        else begin
          m_highs++;
          if (m_highs >= STB_C) begin
            m_retry = 0;
            enter(PH_RUN);
          end
        end
      end
      PH_RUN: begin
        if (!seen) lock_lost();
        else if (cfg_valid) begin
          m_psda = cfg_psda; m_duty = cfg_dutyda; m_fdly = cfg_fdly;
          enter(PH_ADJ);
        end
      end
      PH_ADJ: begin
        if (!seen) lock_lost();
        else begin
          m_elapsed++;
          if (m_elapsed == SET_C) enter(PH_RUN);
        end
      end
      default: ;
    endcase
  endtask

  // One clock: predict from the inputs currently driven, then queue the prediction.
  task automatic tick();
    out_t e;
    model_step();
    e = model_out();
    @(posedge clkin);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_now(input string name, input out_t want);
    out_t got;
    got = dut_out();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge clkin) begin
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = dut_out();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs got=%h want=%h (rst=%b rdy=%b flt=%b retry=%0d) t=%0t",
                 a, e, a.sys_rst, a.ready, a.fault, a.retry, $time);
      end
    end
  end

  task automatic rand_cfg();
    cfg_psda   = 4'($urandom_range(0, 15));
    cfg_dutyda = 4'($urandom_range(0, 15));
    cfg_fdly   = 4'($urandom_range(0, 15));
  endtask

  initial begin
    out_t rst_out;
    int   hold;
    rst_out = '{pll_reset: 1'b1, pll_reset_p: 1'b0, psda: 4'h0, dutyda: 4'b1000,
                fdly: 4'h0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0,
                cfg_ready: 1'b0, retry: 4'h0};
    reset = 1'b1; restart = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0;
    cfg_psda = 4'h0; cfg_dutyda = 4'h0; cfg_fdly = 4'h0;
    model_reset();
    #1 check_now("reset_state", rst_out);
    repeat (3) tick();
    reset = 1'b0;

    // Power-up lock: lock rises after 10 cycles, runs to RUN.
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (14) tick();

    // Config change then a held back-to-back request.
    cfg_valid = 1'b1; cfg_psda = 4'h5; cfg_dutyda = 4'h6; cfg_fdly = 4'h3;
    tick();
    cfg_psda = 4'h9; cfg_dutyda = 4'h2; cfg_fdly = 4'h7;
    repeat (8) tick();
    cfg_valid = 1'b0;
    repeat (3) tick();

    repeat (40) begin
      cfg_valid = 1'($urandom_range(0, 1));
      rand_cfg();
      tick();
    end
    cfg_valid = 1'b0;

    // Lock glitch during STABLE.
    restart = 1'b1; tick(); restart = 1'b0;
    repeat (7) tick();
    pll_lock = 1'b0; repeat (3) tick();
    pll_lock = 1'b1; repeat (16) tick();

    // Lock loss in RUN.
    pll_lock = 1'b0; repeat (6) tick();
    pll_lock = 1'b1; repeat (20) tick();

    // Three timeouts into FAULT, then recovery by restart.
    pll_lock = 1'b0;
    restart = 1'b1; tick(); restart = 1'b0;
    repeat (3 * (RST_C + TMO_C) + 6) tick();
    pll_lock = 1'b1;
    restart = 1'b1; tick(); restart = 1'b0;
    repeat (20) tick();

    // Asynchronous reset in the middle of ADJUST.
    cfg_valid = 1'b1; rand_cfg(); tick();
    cfg_valid = 1'b0; repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1 check_now("async_reset", rst_out);
    total++;
    if (pll_dutyda !== 4'b1000) begin
      bad++;
      $display("FAIL async_reset_duty got=%b want=1000", pll_dutyda);
    end
    repeat (2) tick();
    reset = 1'b0;

    // Random soak: lock held for random spans, occasional restart, random requests.
    hold = 0;
    repeat (600) begin
      if (hold == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        hold = pll_lock ? $urandom_range(5, 60) : $urandom_range(1, 30);
      end
      hold--;
      restart   = ($urandom_range(0, 59) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      rand_cfg();
      tick();
    end
    restart = 1'b0; cfg_valid = 1'b0;

    @(negedge clkin);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
